ring_stop: RTL and testbench
============================

Name: ring_stop

Overview:
- One ring stop per bank, sitting directly between the bank's router-side port and the inter-bank unidirectional packet ring.
- Ejects ring packets addressed to its bank into the bank.
- Injects bank-produced packets onto the ring, looping back locally-addressed packets.
- Diverts CTRL_DONE packets to a dedicated done channel toward the top-level completion collector.

Parameters:
- BANK_ID, 0, index of this stop's bank; matched against pkt.addr.y
- RING_DEPTH, 4, entries in the ring-input FIFO (power of 2, >=2)
- INJ_DEPTH, 4, entries in the bank-injection FIFO (power of 2, >=2)
- STARVE_LIMIT, 8, consecutive injection losses before injection gets forced priority (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ring_valid_in  in  1  packet valid from upstream ring stop
- ring_ready_in  out  1  ring-input FIFO can accept
- ring_in_pkt  in  $bits(pkt_t)  packet from upstream stop
- ring_valid_out  out  1  packet valid to downstream stop
- ring_ready_out  in  1  downstream stop accepts
- ring_out_pkt  out  $bits(pkt_t)  packet to downstream stop
- bank_valid_in  in  1  packet from bank (bank router_valid_out)
- bank_ready_in  out  1  injection FIFO can accept (drives bank router_ready_out)
- bank_in_pkt  in  $bits(pkt_t)  packet from bank
- bank_valid_out  out  1  ejected packet to bank (bank router_valid_in)
- bank_ready_out  in  1  bank accepts (bank router_ready_in)
- bank_out_pkt  out  $bits(pkt_t)  ejected packet
- done_valid  out  1  CTRL_DONE packet valid
- done_ready  in  1  collector accepts
- done_pkt  out  $bits(pkt_t)  the CTRL_DONE packet

Behaviour:
- Clock and reset: single clock `clk`. `rst` is asynchronous and active-low.
- Reset state (rst low):
  - FIFOs empty.
  - All *_valid_out and done_valid are 0; all *_pkt outputs are '0.
  - Ready outputs are 0.
  - FSM is NORMAL; starve counter is 0.
- Ready generation: ring_ready_in = !ring_fifo_full and bank_ready_in = !inj_fifo_full, each from a registered flag. Neither depends on any valid input.
- Push: a packet is pushed when valid && ready.
- Simultaneous push and pop on the same FIFO in one cycle is legal when the FIFO is not full.
- Three output registers (RING, EJECT, DONE):
  - Each register can load when it is empty, or when its valid and ready are both high in the current cycle. This gives full throughput with no bubbles.
  - A register holds its packet stable until accepted.
- Routing:
  - Ring FIFO head with addr.y==BANK_ID goes to EJECT; otherwise it goes to RING.
  - Injection head with ctrl==CTRL_DONE goes to DONE, regardless of addr.
  - Injection head with addr.y==BANK_ID goes to EJECT (loopback); otherwise it goes to RING.
- Arbitration: a conflict is both heads targeting the same output register in one cycle.
  - NORMAL: the ring head wins the conflict.
  - STARVED: the injection head wins once.
  - Non-conflicting heads both advance in the same cycle.
- Starve FSM:
  - In NORMAL, the counter increments on every cycle the injection head loses a conflict.
  - Any injection pop, or the injection FIFO going empty, clears the counter.
  - When the counter reaches STARVE_LIMIT, the next state is STARVED.
  - STARVED returns to NORMAL and clears the counter on the cycle the injection head is popped.
- Latency: ring_in to ring_out is 2 cycles minimum (FIFO write at edge N, output register load at edge N+1). bank_in to ring_out and to done are also 2 cycles.
- Backpressure: a blocked output register stalls only the heads routed to it. The other FIFO keeps draining to free registers.
- Ordering: per-source FIFO order is preserved per destination. No ordering is guaranteed between ring and injection sources.
- Reset mid-operation: all in-flight packets are discarded, with no partial outputs.

Optional Feature:
- RING_STOP_STATS_EN defined:
  - Adds outputs stat_ejected, stat_forwarded, stat_injected and stat_starve, each 32 bits.
  - The first three increment on acceptance at the corresponding output or input handshake.
  - stat_starve increments on each NORMAL->STARVED transition.
  - All counters wrap and reset to 0.
- RING_STOP_STATS_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- types package: pkt_t, addr fields (x/y/z), ctrl enum including CTRL_DONE.
- parameters package: NUM_BANKS, bank-index width.
- Sub-module sync_fifo (parameterised DEPTH and element type, async active-low reset, full/empty flags), instantiated twice.

Test Plan:
- Basic forwarding: BANK_ID=2, single ring packet addr.y=3, all readies high -> same packet on ring_out exactly 2 cycles later; bank_valid_out stays 0.
- Ejection: ring packet addr.y=2 -> bank_valid_out high 2 cycles later with identical packet; ring_valid_out stays 0.
- DONE diversion: bank injects ctrl=CTRL_DONE, addr.y=3 -> appears only on done_pkt. With done_ready=0 held 5 cycles, done_valid stays high with the packet stable, and ring traffic continues flowing.
- Starvation: STARVE_LIMIT=3, continuous ring packets addr.y=5 plus one injected packet addr.y=6 -> injection packet emitted on ring_out after exactly 3 lost conflicts; FSM returns to NORMAL.
- Full/backpressure: ring_ready_out=0 with 6 ring packets sent, RING_DEPTH=4 -> ring_ready_in drops after 4+1 accepted. Releasing ready drains all in order, with no loss or duplication.
- Async reset: assert rst low mid-stream between clock edges -> all valids drop immediately. After release, ready outputs rise and no stale packets emerge.

Source files
------------

// File: rtl/ring_stop_pkg.sv
// ring_stop shared packages: bank-index parameters, packet types and
// the routing helpers used by the ring stop top.
package ring_stop_params_pkg;
    localparam int NUM_BANKS = 8;
    localparam int BANK_W    = $clog2(NUM_BANKS);
endpackage

package ring_stop_pkg;
    import ring_stop_params_pkg::*;

    typedef enum logic [1:0] {
        CTRL_DATA,
        CTRL_REQ,
        CTRL_RSP,
        CTRL_DONE
    } ctrl_e;

    typedef struct packed {
        logic [BANK_W-1:0] x;
        logic [BANK_W-1:0] y;
        logic [BANK_W-1:0] z;
    } addr_t;

    typedef struct packed {
        ctrl_e       ctrl;
        addr_t       addr;
        logic [31:0] data;
    } pkt_t;

    // Output register selector; value 3 is never produced.
    typedef enum logic [1:0] {
        DST_RING,
        DST_EJECT,
        DST_DONE
    } dst_e;

    typedef enum logic {
        ST_NORMAL,
        ST_STARVED
    } starve_e;

    function automatic dst_e route_ring(input pkt_t p,
                                        input logic [BANK_W-1:0] id);
        return (p.addr.y == id) ? DST_EJECT : DST_RING;
    endfunction

    // DONE packets leave on the done channel whatever their address.
    function automatic dst_e route_inj(input pkt_t p,
                                       input logic [BANK_W-1:0] id);
        if (p.ctrl == CTRL_DONE) return DST_DONE;
        return route_ring(p, id);
    endfunction
endpackage

// File: rtl/ring_stop_fifo.sv
// sync_fifo: power-of-2 depth FIFO with registered full/empty flags.
// Ports: clk, rst (async active-low), push_i/data_i, pop_i, data_o
// (head, valid when !empty_o), full_o, empty_o.
module sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        full_d  = (cnt_d == (AW+1)'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage needs no reset: the head is only consumed when !empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

// File: rtl/ring_stop.sv
// ring_stop: per-bank stop on the unidirectional packet ring. Ejects
// packets for this bank, injects bank packets (loopback when local),
// and diverts CTRL_DONE packets to the done channel.
// Ports: ring_* (upstream in / downstream out), bank_* (bank router
// side), done_* (completion collector). clk, rst (async active-low).
// Optional: RING_STOP_STATS_EN adds 32-bit stat_ejected,
// stat_forwarded, stat_injected and stat_starve counters.
module ring_stop
    import ring_stop_params_pkg::*;
    import ring_stop_pkg::*;
#(
    parameter int BANK_ID      = 0,
    parameter int RING_DEPTH   = 4,
    parameter int INJ_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ring_valid_in,
    output logic        ring_ready_in,
    input  pkt_t        ring_in_pkt,
    output logic        ring_valid_out,
    input  logic        ring_ready_out,
    output pkt_t        ring_out_pkt,
    input  logic        bank_valid_in,
    output logic        bank_ready_in,
    input  pkt_t        bank_in_pkt,
    output logic        bank_valid_out,
    input  logic        bank_ready_out,
    output pkt_t        bank_out_pkt,
`ifdef RING_STOP_STATS_EN
    output logic [31:0] stat_ejected,
    output logic [31:0] stat_forwarded,
    output logic [31:0] stat_injected,
    output logic [31:0] stat_starve,
`endif
    output logic        done_valid,
    input  logic        done_ready,
    output pkt_t        done_pkt
);
    localparam logic [BANK_W-1:0] MY_Y = BANK_W'(BANK_ID);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic          up_q;
    pkt_t          ring_head, inj_head;
    logic          ring_full, ring_empty;
    logic          inj_full, inj_empty;
    logic          ring_push, inj_push;
    dst_e          ring_dst, inj_dst;
    logic [3:0]    free;
    logic          conflict, ring_go, inj_go, inj_lost;

    logic          rvld_q, rvld_d;
    pkt_t          rpkt_q, rpkt_d;
    logic          evld_q, evld_d;
    pkt_t          epkt_q, epkt_d;
    logic          dvld_q, dvld_d;
    pkt_t          dpkt_q, dpkt_d;

    starve_e       st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Readies stay low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) up_q <= 1'b0;
        else      up_q <= 1'b1;
    end

    assign ring_ready_in = up_q && !ring_full;
    assign bank_ready_in = up_q && !inj_full;
    assign ring_push     = ring_valid_in && ring_ready_in;
    assign inj_push      = bank_valid_in && bank_ready_in;

    sync_fifo #(.DEPTH(RING_DEPTH), .T(pkt_t)) u_ring_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ring_push),
        .data_i  (ring_in_pkt),
        .pop_i   (ring_go),
        .data_o  (ring_head),
        .full_o  (ring_full),
        .empty_o (ring_empty)
    );

    sync_fifo #(.DEPTH(INJ_DEPTH), .T(pkt_t)) u_inj_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inj_push),
        .data_i  (bank_in_pkt),
        .pop_i   (inj_go),
        .data_o  (inj_head),
        .full_o  (inj_full),
        .empty_o (inj_empty)
    );

    assign ring_dst = route_ring(ring_head, MY_Y);
    assign inj_dst  = route_inj(inj_head, MY_Y);

    // A register is free when empty or draining this cycle.
    assign free = {1'b0,
                   !dvld_q || done_ready,
                   !evld_q || bank_ready_out,
                   !rvld_q || ring_ready_out};

    assign conflict = !ring_empty && !inj_empty && (ring_dst == inj_dst);
    assign ring_go  = !ring_empty && free[ring_dst]
                   && !(conflict && st_q == ST_STARVED);
    assign inj_go   = !inj_empty && free[inj_dst]
                   && !(conflict && st_q == ST_NORMAL);
    // Only a conflict the ring head actually wins counts as a loss.
    assign inj_lost = conflict && st_q == ST_NORMAL && free[inj_dst];

    always_comb begin
        rvld_d = rvld_q;
        rpkt_d = rpkt_q;
        evld_d = evld_q;
        epkt_d = epkt_q;
        dvld_d = dvld_q;
        dpkt_d = dpkt_q;

        if (ring_go && ring_dst == DST_RING) begin
            rvld_d = 1'b1;
            rpkt_d = ring_head;
        end else if (inj_go && inj_dst == DST_RING) begin
            rvld_d = 1'b1;
            rpkt_d = inj_head;
        end else if (ring_ready_out) begin
            rvld_d = 1'b0;
        end

        if (ring_go && ring_dst == DST_EJECT) begin
            evld_d = 1'b1;
            epkt_d = ring_head;
        end else if (inj_go && inj_dst == DST_EJECT) begin
            evld_d = 1'b1;
            epkt_d = inj_head;
        end else if (bank_ready_out) begin
            evld_d = 1'b0;
        end

        if (inj_go && inj_dst == DST_DONE) begin
            dvld_d = 1'b1;
            dpkt_d = inj_head;
        end else if (done_ready) begin
            dvld_d = 1'b0;
        end
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        unique case (st_q)
            ST_NORMAL: begin
                if (inj_go || inj_empty) cnt_d = '0;
                else if (inj_lost)       cnt_d = cnt_q + CW'(1);
                if (cnt_d == CW'(STARVE_LIMIT)) st_d = ST_STARVED;
            end
            ST_STARVED: begin
                if (inj_go || inj_empty) begin
                    st_d  = ST_NORMAL;
                    cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvld_q <= 1'b0;
            rpkt_q <= '0;
            evld_q <= 1'b0;
            epkt_q <= '0;
            dvld_q <= 1'b0;
            dpkt_q <= '0;
            st_q   <= ST_NORMAL;
            cnt_q  <= '0;
        end else begin
            rvld_q <= rvld_d;
            rpkt_q <= rpkt_d;
            evld_q <= evld_d;
            epkt_q <= epkt_d;
            dvld_q <= dvld_d;
            dpkt_q <= dpkt_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ring_valid_out = rvld_q;
    assign ring_out_pkt   = rpkt_q;
    assign bank_valid_out = evld_q;
    assign bank_out_pkt   = epkt_q;
    assign done_valid     = dvld_q;
    assign done_pkt       = dpkt_q;

`ifdef RING_STOP_STATS_EN
    logic [31:0] ej_q, fw_q, in_q, sv_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ej_q <= '0;
            fw_q <= '0;
            in_q <= '0;
            sv_q <= '0;
        end else begin
            if (evld_q && bank_ready_out) ej_q <= ej_q + 32'd1;
            if (rvld_q && ring_ready_out) fw_q <= fw_q + 32'd1;
            if (inj_push)                 in_q <= in_q + 32'd1;
            if (st_q == ST_NORMAL && st_d == ST_STARVED)
                sv_q <= sv_q + 32'd1;
        end
    end

    assign stat_ejected   = ej_q;
    assign stat_forwarded = fw_q;
    assign stat_injected  = in_q;
    assign stat_starve    = sv_q;
`endif
endmodule

// File: tb/tb_ring_stop.sv
// tb_ring_stop: directed self-checking bench for ring_stop
// (BANK_ID=2, depths 4, STARVE_LIMIT=3).
module tb_ring_stop;
    import ring_stop_params_pkg::*;
    import ring_stop_pkg::*;

    logic clk, rst;
    logic ring_valid_in, ring_ready_in, ring_valid_out, ring_ready_out;
    logic bank_valid_in, bank_ready_in, bank_valid_out, bank_ready_out;
    logic done_valid, done_ready;
    pkt_t ring_in_pkt, ring_out_pkt, bank_in_pkt, bank_out_pkt, done_pkt;
`ifdef RING_STOP_STATS_EN
    logic [31:0] stat_ejected, stat_forwarded, stat_injected, stat_starve;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;

    ring_stop #(
        .BANK_ID(2), .RING_DEPTH(4), .INJ_DEPTH(4), .STARVE_LIMIT(3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ring_valid_in  (ring_valid_in),
        .ring_ready_in  (ring_ready_in),
        .ring_in_pkt    (ring_in_pkt),
        .ring_valid_out (ring_valid_out),
        .ring_ready_out (ring_ready_out),
        .ring_out_pkt   (ring_out_pkt),
        .bank_valid_in  (bank_valid_in),
        .bank_ready_in  (bank_ready_in),
        .bank_in_pkt    (bank_in_pkt),
        .bank_valid_out (bank_valid_out),
        .bank_ready_out (bank_ready_out),
        .bank_out_pkt   (bank_out_pkt),
`ifdef RING_STOP_STATS_EN
        .stat_ejected   (stat_ejected),
        .stat_forwarded (stat_forwarded),
        .stat_injected  (stat_injected),
        .stat_starve    (stat_starve),
`endif
        .done_valid     (done_valid),
        .done_ready     (done_ready),
        .done_pkt       (done_pkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic pkt_t mk(input int y, input ctrl_e c,
                                input logic [31:0] d);
        pkt_t p;
        p = '0;
        p.ctrl   = c;
        p.addr.x = BANK_W'(1);
        p.addr.y = BANK_W'(y);
        p.addr.z = BANK_W'(y + 1);
        p.data   = d;
        return p;
    endfunction

    task automatic idle(input int n);
        ring_valid_in  = 1'b0;
        bank_valid_in  = 1'b0;
        ring_in_pkt    = '0;
        bank_in_pkt    = '0;
        ring_ready_out = 1'b1;
        bank_ready_out = 1'b1;
        done_ready     = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle(2);
        tot_cnt++;
        if ({ring_valid_out, bank_valid_out, done_valid} !== 3'b000)
            $display("FAIL reset_valids: got %b want 000",
                     {ring_valid_out, bank_valid_out, done_valid});
        else pass_cnt++;
        tot_cnt++;
        if ({ring_out_pkt, bank_out_pkt, done_pkt} !== '0)
            $display("FAIL reset_pkts: got %h want 0",
                     {ring_out_pkt, bank_out_pkt, done_pkt});
        else pass_cnt++;
        tot_cnt++;
        if ({ring_ready_in, bank_ready_in} !== 2'b00)
            $display("FAIL reset_readies: got %b want 00",
                     {ring_ready_in, bank_ready_in});
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        tot_cnt++;
        if ({ring_ready_in, bank_ready_in} !== 2'b11)
            $display("FAIL release_readies: got %b want 11",
                     {ring_ready_in, bank_ready_in});
        else pass_cnt++;
    endtask

    task automatic test_forward;
        pkt_t p;
        p = mk(3, CTRL_DATA, 32'hA5A5_0001);
        ring_valid_in = 1'b1;
        ring_in_pkt   = p;
        @(negedge clk);
        ring_valid_in = 1'b0;
        tot_cnt++;
        if (ring_valid_out !== 1'b0)
            $display("FAIL fwd_early: got %b want 0", ring_valid_out);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if (ring_valid_out !== 1'b1 || ring_out_pkt !== p)
            $display("FAIL fwd_out: got %b/%h want 1/%h",
                     ring_valid_out, ring_out_pkt, p);
        else pass_cnt++;
        tot_cnt++;
        if (bank_valid_out !== 1'b0)
            $display("FAIL fwd_no_eject: got %b want 0", bank_valid_out);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if (ring_valid_out !== 1'b0)
            $display("FAIL fwd_once: got %b want 0", ring_valid_out);
        else pass_cnt++;
        idle(2);
    endtask

    task automatic test_eject;
        pkt_t p;
        p = mk(2, CTRL_REQ, 32'h0E0E_0002);
        ring_valid_in = 1'b1;
        ring_in_pkt   = p;
        @(negedge clk);
        ring_valid_in = 1'b0;
        tot_cnt++;
        if (bank_valid_out !== 1'b0)
            $display("FAIL ej_early: got %b want 0", bank_valid_out);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if (bank_valid_out !== 1'b1 || bank_out_pkt !== p)
            $display("FAIL ej_out: got %b/%h want 1/%h",
                     bank_valid_out, bank_out_pkt, p);
        else pass_cnt++;
        tot_cnt++;
        if (ring_valid_out !== 1'b0)
            $display("FAIL ej_no_ring: got %b want 0", ring_valid_out);
        else pass_cnt++;
        idle(3);
    endtask

    task automatic test_done;
        pkt_t d, r;
        int   seen, bad, unstable;
        d = mk(3, CTRL_DONE, 32'hD0E0_0003);
        r = mk(3, CTRL_DATA, 32'h7777_0004);
        done_ready    = 1'b0;
        bank_valid_in = 1'b1;
        bank_in_pkt   = d;
        @(negedge clk);
        bank_valid_in = 1'b0;
        tot_cnt++;
        if (done_valid !== 1'b0)
            $display("FAIL done_early: got %b want 0", done_valid);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if (done_valid !== 1'b1 || done_pkt !== d)
            $display("FAIL done_out: got %b/%h want 1/%h",
                     done_valid, done_pkt, d);
        else pass_cnt++;
        seen = 0;
        bad = 0;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            ring_valid_in = (i == 0);
            ring_in_pkt   = r;
            @(negedge clk);
            if (done_valid !== 1'b1 || done_pkt !== d) unstable++;
            if (ring_valid_out === 1'b1 && ring_out_pkt === r) seen++;
            if ((ring_valid_out === 1'b1 && ring_out_pkt === d)
                || bank_valid_out !== 1'b0) bad++;
        end
        ring_valid_in = 1'b0;
        tot_cnt++;
        if (unstable !== 0)
            $display("FAIL done_hold: got %0d unstable cycles want 0",
                     unstable);
        else pass_cnt++;
        tot_cnt++;
        if (seen !== 1)
            $display("FAIL done_ring_flow: got %0d ring pkts want 1", seen);
        else pass_cnt++;
        tot_cnt++;
        if (bad !== 0)
            $display("FAIL done_leak: got %0d stray outputs want 0", bad);
        else pass_cnt++;
        done_ready = 1'b1;
        @(negedge clk);
        tot_cnt++;
        if (done_valid !== 1'b0)
            $display("FAIL done_accept: got %b want 0", done_valid);
        else pass_cnt++;
        idle(2);
    endtask

    task automatic test_starve;
        pkt_t rp [8];
        pkt_t inj;
        pkt_t outq [$];
        int   idx, k, err;
        for (int i = 0; i < 8; i++)
            rp[i] = mk(5, CTRL_DATA, 32'h5500_0000 + i);
        inj = mk(6, CTRL_RSP, 32'h6600_00AA);
        for (int c = 0; c < 16; c++) begin
            ring_valid_in = (c < 8);
            ring_in_pkt   = (c < 8) ? rp[c] : '0;
            bank_valid_in = (c == 0);
            bank_in_pkt   = inj;
            @(negedge clk);
            if (ring_valid_out === 1'b1) outq.push_back(ring_out_pkt);
        end
        ring_valid_in = 1'b0;
        bank_valid_in = 1'b0;
        idx = -1;
        for (int i = 0; i < outq.size(); i++)
            if (outq[i] === inj) idx = i;
        tot_cnt++;
        if (outq.size() !== 9)
            $display("FAIL starve_count: got %0d pkts want 9", outq.size());
        else pass_cnt++;
        tot_cnt++;
        if (idx !== 3)
            $display("FAIL starve_losses: got %0d want 3", idx);
        else pass_cnt++;
        k = 0;
        err = 0;
        for (int i = 0; i < outq.size(); i++) begin
            if (i != idx) begin
                if (k >= 8 || outq[i] !== rp[k]) err++;
                k++;
            end
        end
        tot_cnt++;
        if (err !== 0)
            $display("FAIL starve_order: got %0d misordered want 0", err);
        else pass_cnt++;
        tot_cnt++;
        if (dut.st_q !== ST_NORMAL || dut.cnt_q !== '0)
            $display("FAIL starve_recover: got %0d/%0d want 0/0",
                     dut.st_q, dut.cnt_q);
        else pass_cnt++;
        idle(2);
    endtask

    task automatic test_backpressure;
        pkt_t bp [6];
        pkt_t outq [$];
        int   sent, err;
        for (int i = 0; i < 6; i++)
            bp[i] = mk(3, CTRL_DATA, 32'hBB00_0000 + i);
        ring_ready_out = 1'b0;
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            ring_valid_in = (sent < 6);
            ring_in_pkt   = (sent < 6) ? bp[sent] : '0;
            if (ring_ready_in === 1'b1 && sent < 6) sent++;
            @(negedge clk);
        end
        tot_cnt++;
        if (sent !== 5)
            $display("FAIL bp_accepted: got %0d want 5", sent);
        else pass_cnt++;
        tot_cnt++;
        if (ring_ready_in !== 1'b0)
            $display("FAIL bp_ready_low: got %b want 0", ring_ready_in);
        else pass_cnt++;
        tot_cnt++;
        if (ring_valid_out !== 1'b1 || ring_out_pkt !== bp[0])
            $display("FAIL bp_hold: got %b/%h want 1/%h",
                     ring_valid_out, ring_out_pkt, bp[0]);
        else pass_cnt++;
        ring_ready_out = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (ring_valid_out === 1'b1) outq.push_back(ring_out_pkt);
            ring_valid_in = (sent < 6);
            ring_in_pkt   = (sent < 6) ? bp[sent] : '0;
            if (ring_ready_in === 1'b1 && sent < 6) sent++;
            @(negedge clk);
        end
        ring_valid_in = 1'b0;
        err = 0;
        for (int i = 0; i < outq.size(); i++)
            if (i >= 6 || outq[i] !== bp[i]) err++;
        tot_cnt++;
        if (outq.size() !== 6 || sent !== 6)
            $display("FAIL bp_drain_count: got %0d out %0d sent want 6/6",
                     outq.size(), sent);
        else pass_cnt++;
        tot_cnt++;
        if (err !== 0)
            $display("FAIL bp_drain_order: got %0d bad want 0", err);
        else pass_cnt++;
        idle(2);
    endtask

    task automatic test_async_reset;
        int stale;
        ring_ready_out = 1'b0;
        bank_ready_out = 1'b0;
        done_ready     = 1'b0;
        ring_valid_in  = 1'b1;
        ring_in_pkt    = mk(3, CTRL_DATA, 32'hCC00_0001);
        bank_valid_in  = 1'b1;
        bank_in_pkt    = mk(3, CTRL_DONE, 32'hCC00_0002);
        @(negedge clk);
        bank_valid_in = 1'b0;
        ring_in_pkt   = mk(2, CTRL_DATA, 32'hCC00_0003);
        @(negedge clk);
        ring_in_pkt = mk(3, CTRL_DATA, 32'hCC00_0004);
        @(negedge clk);
        ring_valid_in = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if ({ring_valid_out, bank_valid_out, done_valid} !== 3'b111)
            $display("FAIL arst_pre: got %b want 111",
                     {ring_valid_out, bank_valid_out, done_valid});
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        tot_cnt++;
        if ({ring_valid_out, bank_valid_out, done_valid,
             ring_ready_in, bank_ready_in} !== 5'b00000)
            $display("FAIL arst_drop: got %b want 00000",
                     {ring_valid_out, bank_valid_out, done_valid,
                      ring_ready_in, bank_ready_in});
        else pass_cnt++;
        tot_cnt++;
        if ({ring_out_pkt, bank_out_pkt, done_pkt} !== '0)
            $display("FAIL arst_pkts: got %h want 0",
                     {ring_out_pkt, bank_out_pkt, done_pkt});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        ring_ready_out = 1'b1;
        bank_ready_out = 1'b1;
        done_ready     = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ring_valid_out !== 1'b0 || bank_valid_out !== 1'b0
                || done_valid !== 1'b0) stale++;
        end
        tot_cnt++;
        if (stale !== 0)
            $display("FAIL arst_stale: got %0d valid cycles want 0", stale);
        else pass_cnt++;
        tot_cnt++;
        if ({ring_ready_in, bank_ready_in} !== 2'b11)
            $display("FAIL arst_ready: got %b want 11",
                     {ring_ready_in, bank_ready_in});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_eject();
        test_done();
        test_starve();
        test_backpressure();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
